phi0_bus_ctrl: RTL and testbench
================================

Name: phi0_bus_ctrl

Overview:
- Consumes the PHI0 CPU clock generated from CLK_SRC and produces the 6502-side bus timing in the CLK_SRC domain.
- Generates memory strobes (OE_N, WE_N), one-cycle PHI0 edge pulses and a completed-CPU-cycle counter.
- Inserts RDY wait states for accesses the address decoder flags as slow.
- Sits between the CPU clock divider and the memory/peripheral chip selects in the decoder CPLD.

Parameters:
- WAIT_CYCLES, 2, extra PHI0 periods added to a slow access (0 disables wait insertion).
- WE_DELAY, 1, CLK_SRC cycles after PHI0 rise before WE_N may assert (range 0..7).
- CNT_WIDTH, 16, width of CYCLE_COUNT.

Ports:
- CLK_SRC  input  1  system clock, 50 MHz.
- RST  input  1  asynchronous active-high reset.
- PHI0  input  1  CPU clock, registered in the CLK_SRC domain (no synchroniser needed).
- RWB  input  1  CPU read/write, 1 = read.
- SLOW_SEL  input  1  decoder flag: current address targets a slow device.
- RDY  output  1  to CPU RDY pin; 0 stretches the current cycle.
- OE_N  output  1  active-low read strobe.
- WE_N  output  1  active-low write strobe.
- PHI0_RISE  output  1  one-CLK_SRC pulse on PHI0 rising.
- PHI0_FALL  output  1  one-CLK_SRC pulse on PHI0 falling.
- CYCLE_COUNT  output  CNT_WIDTH  completed CPU bus cycles, wraps.

Behaviour:
- Reset (async, RST=1): RDY=1, OE_N=1, WE_N=1, state IDLE, wcnt=0, phase=0, phi0_q=0, CYCLE_COUNT=0. Release is synchronous to the next CLK_SRC edge.
- Edge detect:
  - phi0_q <= PHI0 every clock.
  - PHI0_RISE = PHI0 & ~phi0_q; PHI0_FALL = ~PHI0 & phi0_q. Both are decoded from flops, exactly one cycle wide.
  - No pulse is produced in the first cycle after reset if PHI0=0.
- phase counter (3 bits):
  - 0 in the PHI0_RISE cycle, incrementing each clock while PHI0=1, saturating at 7.
  - Cleared while PHI0=0.
- Strobes are registered; value at edge n+1 is computed from cycle n.
  - OE_N next = ~(PHI0 & RWB).
  - WE_N next = ~(PHI0 & ~RWB & (phase >= WE_DELAY)).
  - Both deassert on the first edge after PHI0 is sampled 0.
  - RWB changing mid-high-phase follows the same equations; there is no latching.
- Wait FSM, states IDLE, WAIT, RECOVER. All transitions happen only on PHI0_RISE or PHI0_FALL cycles.
  - IDLE, on PHI0_RISE with SLOW_SEL=1 and WAIT_CYCLES>0: RDY<=0, wcnt<=WAIT_CYCLES, go to WAIT.
  - WAIT, on PHI0_FALL: wcnt<=wcnt-1. If wcnt==1, RDY<=1 and go to RECOVER.
  - WAIT and RECOVER: PHI0_RISE is ignored. SLOW_SEL stays asserted for the same access and must not retrigger.
  - RECOVER, on PHI0_FALL: go to IDLE. The CPU samples RDY=1 here and completes the access.
  - Net effect: a slow access lasts WAIT_CYCLES+1 PHI0 periods.
  - With WAIT_CYCLES=0 the FSM never leaves IDLE and RDY stays 1.
- CYCLE_COUNT increments by 1 on each PHI0_FALL where the state before the edge is IDLE or RECOVER, i.e. RDY was 1 at the CPU sample. It wraps from 2^CNT_WIDTH-1 to 0.
- Reset during WAIT: RDY returns to 1 immediately (async) and the FSM goes to IDLE. The interrupted access is not counted.
- PHI0 stuck (no edges): all state holds, and the strobes follow the level equations.
- With DIVISOR 8, PHI0 is high for 4 clocks and low for 4. WE_DELAY must be < 4 for WE_N to assert at all; larger values simply suppress WE_N. This is not an error.

Test Plan:
- Reset, then 8-clock PHI0 (4 high/4 low): PHI0_RISE/FALL each exactly 1 clock per period; RDY=1, OE_N=1, WE_N=1 until the first PHI0 high.
- Read, RWB=1, SLOW_SEL=0: OE_N low for exactly 4 clocks, lagging PHI0 by 1 clock; WE_N stays 1; CYCLE_COUNT increments by 1 per PHI0 fall.
- Write, RWB=0, WE_DELAY=1: WE_N low for 3 clocks, asserting 2 clocks after PHI0 rises and deasserting 1 clock after PHI0 falls; OE_N stays 1.
- Slow access, SLOW_SEL=1 held, WAIT_CYCLES=2:
  - RDY low from the clock after the first rise through the second fall.
  - RDY high before the third fall.
  - CYCLE_COUNT +1 only at the third fall.
  - A new access at the fourth rise with SLOW_SEL=1 retriggers.
- RST pulse mid-WAIT (after the first fall): RDY=1 asynchronously in the same cycle; the FSM resumes from IDLE; CYCLE_COUNT=0.
- CNT_WIDTH=4: 17 fast cycles give CYCLE_COUNT sequence ...14, 15, 0, 1.

Source files
------------

// File: rtl/phi0_bus_ctrl.sv
// ============================================================================
// Module   : phi0_bus_ctrl
// Purpose  : 6502 bus timing in the CLK_SRC domain: PHI0 edge pulses,
//            registered OE_N/WE_N strobes, RDY wait-state insertion for
//            slow devices and a completed-bus-cycle counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module phi0_bus_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int WE_DELAY    = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 CLK_SRC,
  input  logic                 RST,
  input  logic                 PHI0,
  input  logic                 RWB,
  input  logic                 SLOW_SEL,
  output logic                 RDY,
  output logic                 OE_N,
  output logic                 WE_N,
  output logic                 PHI0_RISE,
  output logic                 PHI0_FALL,
  output logic [CNT_WIDTH-1:0] CYCLE_COUNT
);

  localparam int                WCNT_W      = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WCNT_W-1:0] C_WAIT_LOAD = WCNT_W'(WAIT_CYCLES);
  localparam logic [WCNT_W-1:0] C_WCNT_ONE  = WCNT_W'(1);
  localparam logic [2:0]        C_WE_DELAY  = 3'(WE_DELAY);
  localparam logic              C_WAIT_EN   = (WAIT_CYCLES > 0);
  localparam logic              C_WE_NODLY  = (WE_DELAY == 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  logic                 r_phi0_q;
  logic [2:0]           r_phase;
  state_t               r_state;
  logic [WCNT_W-1:0]    r_wcnt;
  logic                 r_rdy;
  logic                 r_oe_n;
  logic                 r_we_n;
  logic [CNT_WIDTH-1:0] r_count;

  logic                 w_rise;
  logic                 w_fall;
  logic                 w_phase_ok;
  state_t               w_state_nxt;
  logic [WCNT_W-1:0]    w_wcnt_nxt;
  logic                 w_rdy_nxt;
  logic                 w_count_inc;

  assign w_rise     = PHI0 & ~r_phi0_q;
  assign w_fall     = ~PHI0 & r_phi0_q;
  assign w_phase_ok = C_WE_NODLY | (r_phase >= C_WE_DELAY);

  // Edge history, high-phase position and the registered strobes.
  always_ff @(posedge CLK_SRC or posedge RST) begin
    if (RST) begin
      r_phi0_q <= 1'b0;
      r_phase  <= 3'd0;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
    end else begin
      r_phi0_q <= PHI0;
      if (!PHI0) begin
        r_phase <= 3'd0;
      end else if (r_phase != 3'd7) begin
        r_phase <= r_phase + 3'd1;
      end
      r_oe_n <= ~(PHI0 & RWB);
      r_we_n <= ~(PHI0 & ~RWB & w_phase_ok);
    end
  end

  // Wait-state FSM: only PHI0 edge cycles can move it.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_rdy_nxt   = r_rdy;
    w_count_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise && SLOW_SEL && C_WAIT_EN) begin
          w_rdy_nxt   = 1'b0;
          w_wcnt_nxt  = C_WAIT_LOAD;
          w_state_nxt = ST_WAIT;
        end else if (w_fall) begin
          w_count_inc = 1'b1;
        end
      end
      ST_WAIT: begin
        if (w_fall) begin
          w_wcnt_nxt = r_wcnt - C_WCNT_ONE;
          if (r_wcnt == C_WCNT_ONE) begin
            w_rdy_nxt   = 1'b1;
            w_state_nxt = ST_RECOVER;
          end
        end
      end
      ST_RECOVER: begin
        // RDY was already 1 when the CPU sampled, so this access completes.
        if (w_fall) begin
          w_count_inc = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_rdy_nxt   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_SRC or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_wcnt  <= '0;
      r_rdy   <= 1'b1;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_rdy   <= w_rdy_nxt;
      if (w_count_inc) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end
    end
  end

  assign RDY         = r_rdy;
  assign OE_N        = r_oe_n;
  assign WE_N        = r_we_n;
  assign PHI0_RISE   = w_rise;
  assign PHI0_FALL   = w_fall;
  assign CYCLE_COUNT = r_count;

endmodule

`default_nettype wire

// File: tb/tb_phi0_bus_ctrl.sv
// ============================================================================
// Module   : tb_phi0_bus_ctrl
// Purpose  : Directed bench for phi0_bus_ctrl with a cycle-level bus model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_phi0_bus_ctrl;

  localparam int WAIT_N = 2;
  localparam int WE_DLY = 1;
  localparam int CW     = 4;

  logic          CLK_SRC  = 1'b0;
  logic          RST      = 1'b1;
  logic          PHI0     = 1'b0;
  logic          RWB      = 1'b1;
  logic          SLOW_SEL = 1'b0;
  logic          RDY;
  logic          OE_N;
  logic          WE_N;
  logic          PHI0_RISE;
  logic          PHI0_FALL;
  logic [CW-1:0] CYCLE_COUNT;

  phi0_bus_ctrl #(
    .WAIT_CYCLES (WAIT_N),
    .WE_DELAY    (WE_DLY),
    .CNT_WIDTH   (CW)
  ) u_dut (
    .CLK_SRC     (CLK_SRC),
    .RST         (RST),
    .PHI0        (PHI0),
    .RWB         (RWB),
    .SLOW_SEL    (SLOW_SEL),
    .RDY         (RDY),
    .OE_N        (OE_N),
    .WE_N        (WE_N),
    .PHI0_RISE   (PHI0_RISE),
    .PHI0_FALL   (PHI0_FALL),
    .CYCLE_COUNT (CYCLE_COUNT)
  );

  always #5 CLK_SRC = ~CLK_SRC;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Bus model: access-level view of each PHI0 period, evaluated mid-cycle.
  logic m_prev  = 1'b0;
  int   m_run   = 0;
  logic m_busy  = 1'b0;
  int   m_stall = 0;
  logic m_oe    = 1'b1;
  logic m_we    = 1'b1;
  logic m_rdy   = 1'b1;
  int   m_cnt   = 0;

  initial begin
    logic er, ef;
    int   ph;
    forever begin
      @(negedge CLK_SRC);
      if (RST) begin
        m_prev = 1'b0; m_run = 0; m_busy = 1'b0; m_stall = 0;
        m_oe = 1'b1; m_we = 1'b1; m_rdy = 1'b1; m_cnt = 0;
      end
      er = PHI0 & ~m_prev;
      ef = ~PHI0 & m_prev;
      chk("rise", 32'(PHI0_RISE), 32'(er));
      chk("fall", 32'(PHI0_FALL), 32'(ef));
      chk("rdy", 32'(RDY), 32'(m_rdy));
      chk("oe_n", 32'(OE_N), 32'(m_oe));
      chk("we_n", 32'(WE_N), 32'(m_we));
      chk("count", 32'(CYCLE_COUNT), 32'(m_cnt));
      if (!RST) begin
        ph   = (m_run > 7) ? 7 : m_run;
        m_oe = ~(PHI0 & RWB);
        m_we = ~(PHI0 & ~RWB & (ph >= WE_DLY));
        if (er && !m_busy && SLOW_SEL && (WAIT_N > 0)) begin
          m_busy  = 1'b1;
          m_stall = WAIT_N;
        end else if (ef) begin
          if (m_busy && m_stall > 0) begin
            m_stall--;
          end else begin
            m_cnt  = (m_cnt + 1) % (1 << CW);
            m_busy = 1'b0;
          end
        end
        m_rdy  = ~(m_busy && m_stall > 0);
        m_run  = PHI0 ? m_run + 1 : 0;
        m_prev = PHI0;
      end
    end
  end

  // Per-cycle log of registered outputs after the edge closing cycle g.
  logic     log_oe  [0:511];
  logic     log_we  [0:511];
  logic     log_rdy [0:511];
  int       log_cnt [0:511];
  int       g      = 0;
  logic     prev_p = 1'b0;
  int       rq[$];
  int       fq[$];

  task automatic step(input logic p, input logic r, input logic s);
    PHI0 = p; RWB = r; SLOW_SEL = s;
    @(posedge CLK_SRC);
    #2;
    if (p && !prev_p) rq.push_back(g);
    if (!p && prev_p) fq.push_back(g);
    log_oe[g]  = OE_N;
    log_we[g]  = WE_N;
    log_rdy[g] = RDY;
    log_cnt[g] = int'(CYCLE_COUNT);
    prev_p = p;
    g++;
  endtask

  task automatic period(input logic r, input logic s, input int hi);
    for (int i = 0; i < hi; i++) step(1'b1, r, s);
    for (int i = 0; i < 4; i++) step(1'b0, r, s);
  endtask

  initial begin
    int lows;
    repeat (3) @(posedge CLK_SRC);
    #2;
    chk("reset_rdy", 32'(RDY), 32'd1);
    chk("reset_oe", 32'(OE_N), 32'd1);
    chk("reset_we", 32'(WE_N), 32'd1);
    chk("reset_cnt", 32'(CYCLE_COUNT), 32'd0);
    RST = 1'b0;

    period(1'b1, 1'b0, 4);   // fast read
    period(1'b0, 1'b0, 4);   // fast write
    period(1'b1, 1'b1, 4);   // slow read: wait 1
    period(1'b1, 1'b1, 4);   // wait 2
    period(1'b1, 1'b1, 4);   // recover, completes
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);  // retrigger
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);

    lows = 0;
    for (int k = 0; k < 8; k++) lows += (log_oe[rq[0] + k] == 1'b0) ? 1 : 0;
    chk("read_oe_low_clocks", 32'(lows), 32'd4);
    chk("read_oe_first", 32'(log_oe[rq[0]]), 32'd0);
    chk("read_oe_end", 32'(log_oe[fq[0]]), 32'd1);
    chk("read_cnt", 32'(log_cnt[fq[0]]), 32'd1);
    lows = 0;
    for (int k = 0; k < 8; k++) lows += (log_we[rq[1] + k] == 1'b0) ? 1 : 0;
    chk("write_we_low_clocks", 32'(lows), 32'd3);
    chk("write_we_rise", 32'(log_we[rq[1]]), 32'd1);
    chk("write_we_on", 32'(log_we[rq[1] + 1]), 32'd0);
    chk("write_we_off", 32'(log_we[fq[1]]), 32'd1);
    chk("write_cnt", 32'(log_cnt[fq[1]]), 32'd2);
    chk("slow_rdy_low", 32'(log_rdy[rq[2]]), 32'd0);
    chk("slow_cnt_fall1", 32'(log_cnt[fq[2]]), 32'd2);
    chk("slow_rdy_last_low", 32'(log_rdy[fq[3] - 1]), 32'd0);
    chk("slow_rdy_release", 32'(log_rdy[fq[3]]), 32'd1);
    chk("slow_cnt_fall2", 32'(log_cnt[fq[3]]), 32'd2);
    chk("slow_no_retrig", 32'(log_rdy[rq[4]]), 32'd1);
    chk("slow_cnt_fall3", 32'(log_cnt[fq[4]]), 32'd3);
    chk("slow_retrig", 32'(log_rdy[rq[5]]), 32'd0);

    // Asynchronous reset in the middle of the wait.
    #1;
    RST = 1'b1;
    #1;
    chk("async_rdy", 32'(RDY), 32'd1);
    chk("async_cnt", 32'(CYCLE_COUNT), 32'd0);
    chk("async_oe", 32'(OE_N), 32'd1);
    @(posedge CLK_SRC);
    #2;
    RST = 1'b0;
    prev_p = 1'b0;
    rq.delete();
    fq.delete();

    for (int p = 0; p < 17; p++) begin
      if (p == 3) begin
        period(1'b0, 1'b0, 12);            // long high phase, write
      end else if (p == 5) begin
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
      end else begin
        period(p[0], 1'b0, 4);
      end
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1);   // PHI0 stuck low

    chk("wrap_14", 32'(log_cnt[fq[13]]), 32'd14);
    chk("wrap_15", 32'(log_cnt[fq[14]]), 32'd15);
    chk("wrap_0", 32'(log_cnt[fq[15]]), 32'd0);
    chk("wrap_1", 32'(log_cnt[fq[16]]), 32'd1);
    chk("stuck_hold", 32'(CYCLE_COUNT), 32'd1);

    repeat (2) @(posedge CLK_SRC);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
